// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2)[x] multiplier and reduction stages:
// FSM state encoding and the polyn_grade port width helper.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Width of a polyn_grade port for field width m (holds 0..m inclusive).
    function automatic int GF_GRADE_W(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/gf_clmul_step.sv
// One shift-and-XOR step of a carry-less multiply:
// acc_o = acc_i ^ (bit_i ? a_i << sh : 0).
module gf_clmul_step #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SH_W       = 4
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic                    bit_i,
    input  logic [SH_W-1:0]         sh,
    output logic [2*DATA_WIDTH-1:0] acc_o
);

    // Conditionally fold the shifted multiplicand into the accumulator.
    always_comb begin
        acc_o = acc_i;
        if (bit_i) begin
            acc_o = acc_i ^ ({{DATA_WIDTH{1'b0}}, a_i} << sh);
        end
    end

endmodule

// File: rtl/gf_clmul_seq.sv
// Sequential carry-less multiplier producing the unreduced product a*b over
// GF(2)[x]. Operands are masked to the low polyn_grade bits at start.
// Build option: define GF_CLMUL_2BIT_EN to consume two multiplier bits per
// cycle (two chained step instances); products are identical either way.
module gf_clmul_seq
    import gf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                op_enable,
    input  logic [GF_GRADE_W(DATA_WIDTH)-1:0]   polyn_grade,
    input  logic [DATA_WIDTH-1:0]               a_in,
    input  logic [DATA_WIDTH-1:0]               b_in,
    output logic [2*DATA_WIDTH-1:0]             out,
    output logic                                op_finish
);

    localparam int GW = GF_GRADE_W(DATA_WIDTH);
    localparam int CW = GW + 1;
    localparam int PW = 2 * DATA_WIDTH;
`ifdef GF_CLMUL_2BIT_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    gf_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [GW-1:0]         g_q, g_d;
    logic [GW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         out_d;
    logic                  fin_d;

    logic [DATA_WIDTH-1:0] mask;
    logic [GW-1:0]         g_clamped;
    logic [STEP-1:0]       b_bits;
    logic [CW-1:0]         cnt_ext;
    logic [CW-1:0]         g_ext;
    logic [CW-1:0]         cnt_next;
    logic                  bit0;
    logic [PW-1:0]         step_acc;

    // Operand mask and effective degree derived from the requested grade.
    always_comb begin
        mask      = '1;
        g_clamped = GW'(DATA_WIDTH);
        if (polyn_grade < GW'(DATA_WIDTH)) begin
            mask      = (DATA_WIDTH'(1) << polyn_grade) - DATA_WIDTH'(1);
            g_clamped = polyn_grade;
        end
    end

    assign b_bits   = STEP'(b_q >> cnt_q);
    assign cnt_ext  = {1'b0, cnt_q};
    assign g_ext    = {1'b0, g_q};
    assign cnt_next = cnt_ext + CW'(STEP);
    // Bits at or beyond g_eff never contribute (they are masked anyway, but
    // the gate also keeps the shift index inside the operand).
    assign bit0     = (cnt_ext < g_ext) & b_bits[0];

`ifdef GF_CLMUL_2BIT_EN
    logic          bit1;
    logic [GW-1:0] sh1;
    logic [PW-1:0] mid_acc;

    // Upper step is gated off on the final cycle of an odd-length operation.
    assign bit1 = ((cnt_ext + CW'(1)) < g_ext) & b_bits[1];
    assign sh1  = cnt_q + GW'(1);

    gf_clmul_step #(.DATA_WIDTH(DATA_WIDTH), .SH_W(GW)) u_step0 (
        .acc_i (acc_q),
        .a_i   (a_q),
        .bit_i (bit0),
        .sh    (cnt_q),
        .acc_o (mid_acc)
    );

    gf_clmul_step #(.DATA_WIDTH(DATA_WIDTH), .SH_W(GW)) u_step1 (
        .acc_i (mid_acc),
        .a_i   (a_q),
        .bit_i (bit1),
        .sh    (sh1),
        .acc_o (step_acc)
    );
`else
    gf_clmul_step #(.DATA_WIDTH(DATA_WIDTH), .SH_W(GW)) u_step0 (
        .acc_i (acc_q),
        .a_i   (a_q),
        .bit_i (bit0),
        .sh    (cnt_q),
        .acc_o (step_acc)
    );
`endif

    // Next-state and next-register logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        out_d   = out;
        fin_d   = op_finish;
        unique case (state_q)
            IDLE: begin
                if (op_enable) begin
                    a_d     = a_in & mask;
                    b_d     = b_in & mask;
                    g_d     = g_clamped;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!op_enable) begin
                    fin_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    cnt_d = cnt_next[GW-1:0];
                    // g_eff = 0 also lands here on the first BUSY edge.
                    if (cnt_next >= g_ext) begin
                        out_d   = step_acc;
                        fin_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!op_enable) begin
                    fin_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            out       <= '0;
            op_finish <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            g_q       <= g_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            out       <= out_d;
            op_finish <= fin_d;
        end
    end

endmodule

// File: tb/tb_gf_clmul_seq.sv
// Self-checking bench for gf_clmul_seq (DATA_WIDTH = 8): vector table,
// hand-written abort/reset sequences and random operations, with expected
// products queued at drive time and compared when op_finish rises.
module tb_gf_clmul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_enable;
    logic [3:0]  polyn_grade;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [15:0] out;
    logic        op_finish;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];
    logic [15:0] last_out;

    typedef struct {
        logic [3:0]  g;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    gf_clmul_seq #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_enable   (op_enable),
        .polyn_grade (polyn_grade),
        .a_in        (a_in),
        .b_in        (b_in),
        .out         (out),
        .op_finish   (op_finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  m;
        logic [15:0] p;
        m = (g >= 4'd8) ? 8'hFF : 8'((16'd1 << g) - 16'd1);
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i] & m[i]) p = p ^ (16'(a & m) << i);
        end
        return p;
    endfunction

    function automatic int exp_latency(input logic [3:0] g);
        int ge;
        ge = (g > 4'd8) ? 8 : int'(g);
        if (ge == 0) return 1;
`ifdef GF_CLMUL_2BIT_EN
        return (ge + 1) / 2;
`else
        return ge;
`endif
    endfunction

    // Run one operation; inputs are scrambled after E0 and while holding.
    task automatic do_op(input logic [3:0] g, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int hold, input bit release_en);
        int cyc;
        logic [15:0] got;
        sb_q.push_back(exp);
        @(negedge clk);
        polyn_grade = g;
        a_in        = a;
        b_in        = b;
        op_enable   = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        polyn_grade = 4'($urandom_range(15, 0));
        a_in        = 8'($urandom_range(255, 0));
        b_in        = 8'($urandom_range(255, 0));
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (op_finish) break;
        end
        got = sb_q.pop_front();
        if (!op_finish) begin
            check("finish_timeout", 16'(op_finish), 16'd1);
        end else begin
            check("latency", 16'(cyc), 16'(exp_latency(g)));
            check("product", out, got);
            last_out = got;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                a_in = 8'($urandom_range(255, 0));
                b_in = 8'($urandom_range(255, 0));
                @(posedge clk); #1;
                check("hold_finish", 16'(op_finish), 16'd1);
                check("hold_out", out, got);
            end
            if (release_en) begin
                @(negedge clk);
                op_enable = 1'b0;
                @(posedge clk); #1;
                check("release_finish", 16'(op_finish), 16'd0);
                check("release_out", out, got);
            end
        end
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{4'd4,  8'h0B, 8'h06, 16'h003A};
        vecs[1] = '{4'd8,  8'hFF, 8'hFF, 16'h5555};
        vecs[2] = '{4'd4,  8'hFB, 8'h16, 16'h003A};
        vecs[3] = '{4'd0,  8'hAB, 8'hCD, 16'h0000};
        vecs[4] = '{4'd8,  8'h80, 8'h80, 16'h4000};
        vecs[5] = '{4'd1,  8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{4'd7,  8'hFF, 8'h81, 16'h007F};
        vecs[7] = '{4'd12, 8'hFF, 8'hFF, 16'h5555};
        vecs[8] = '{4'd3,  8'h05, 8'h07, 16'h001B};
        vecs[9] = '{4'd2,  8'h03, 8'h03, 16'h0005};

        rst_n = 1'b0; op_enable = 1'b0; polyn_grade = '0; a_in = '0; b_in = '0;
        last_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 16'h0000);
        check("reset_finish", 16'(op_finish), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 3 : 1, 1'b1);
        end

        // Abort: op_enable dropped so that E2 sees it low.
        @(negedge clk);
        polyn_grade = 4'd8; a_in = 8'hFF; b_in = 8'hFF; op_enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        op_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("abort_finish", 16'(op_finish), 16'd0);
            check("abort_out", out, last_out);
        end
        do_op(4'd4, 8'h0B, 8'h06, 16'h003A, 1, 1'b1);

        // Reset mid-BUSY.
        @(negedge clk);
        polyn_grade = 4'd8; a_in = 8'hFF; b_in = 8'hFF; op_enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_out", out, 16'h0000);
        check("rst_busy_finish", 16'(op_finish), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; op_enable = 1'b0;
        do_op(4'd4, 8'h0B, 8'h06, 16'h003A, 1, 1'b1);

        // Reset while in DONE with op_enable still high.
        do_op(4'd8, 8'hFF, 8'hFF, 16'h5555, 2, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_done_out", out, 16'h0000);
        check("rst_done_finish", 16'(op_finish), 16'd0);
        @(negedge clk);
        rst_n = 1'b1; op_enable = 1'b0;
        do_op(4'd4, 8'h0B, 8'h06, 16'h003A, 1, 1'b1);

        // Random operations against the reference model.
        for (int n = 0; n < 500; n++) begin
            logic [3:0] g;
            logic [7:0] a, b;
            g = 4'($urandom_range(15, 0));
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            do_op(g, a, b, model(g, a, b), int'($urandom_range(1, 0)), 1'b1);
        end

        check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
